// File: rtl/ppu_relu_maxpool_if.sv
// Valid/ready stream pair around the PPU ReLU/max-pool stage.
// The master side feeds pixels in and collects results; the slave side is the stage.
interface ppu_relu_maxpool_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ppu_relu_maxpool.sv
// Optional ReLU followed by optional 2x2 stride-2 max pooling on an offset-128 pixel stream.
// Row-major input; horizontal pair maxima of even rows are held in a half-row line buffer.
module ppu_relu_maxpool #(
    parameter int MAX_W = 64,
    parameter int LB_AW = $clog2(MAX_W / 2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cfg_relu_en,
    input  logic                   cfg_pool_en,
    input  logic [$clog2(MAX_W):0] cfg_width,
    ppu_relu_maxpool_if.slave      s
);
    localparam int WW   = $clog2(MAX_W) + 1;
    localparam int AW   = (LB_AW < 1) ? 1 : LB_AW;
    localparam int LB_D = MAX_W / 2;

    logic          relu_q;
    logic          pool_q;
    logic [WW-1:0] width_q;
    logic [WW-1:0] col;
    logic          row_odd;
    logic [7:0]    h;
    logic [7:0]    out_data_q;
    logic          out_valid_q;
    logic [7:0]    lb [LB_D];

    logic          in_ready;
    logic          in_fire;
    logic          col_last;
    logic [AW-1:0] k;
    logic [7:0]    p;
    logic [7:0]    m;
    logic [7:0]    lb_rd;
    logic [7:0]    pool_res;

    // Output slot is a single register; a draining output frees it in the same cycle.
    assign in_ready = !start && (!out_valid_q || s.out_ready);
    assign in_fire  = s.in_valid && in_ready;

    assign p        = (relu_q && (s.in_data < 8'd128)) ? 8'd128 : s.in_data;
    assign m        = (h > p) ? h : p;
    assign k        = AW'(col >> 1);
    assign lb_rd    = lb[k];
    assign pool_res = (lb_rd > m) ? lb_rd : m;
    assign col_last = (col == (width_q - WW'(1)));

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relu_q      <= 1'b0;
            pool_q      <= 1'b0;
            width_q     <= WW'(2);
            col         <= '0;
            row_odd     <= 1'b0;
            h           <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (start) begin
            relu_q      <= cfg_relu_en;
            pool_q      <= cfg_pool_en;
            width_q     <= cfg_width;
            col         <= '0;
            row_odd     <= 1'b0;
            h           <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && s.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (in_fire) begin
                if (col_last) begin
                    col     <= '0;
                    row_odd <= !row_odd;
                end else begin
                    col <= col + WW'(1);
                end

                if (!pool_q) begin
                    out_data_q  <= p;
                    out_valid_q <= 1'b1;
                end else if (!col[0]) begin
                    h <= p;
                end else if (row_odd) begin
                    out_data_q  <= pool_res;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    // Written only on even rows and read only on odd rows, so no same-entry collision.
    always_ff @(posedge clk) begin
        if (in_fire && pool_q && col[0] && !row_odd) begin
            lb[k] <= m;
        end
    end
endmodule

// File: tb/tb_ppu_relu_maxpool.sv
// Directed bench for ppu_relu_maxpool: bypass, ReLU, pooling, backpressure and reset.
module tb_ppu_relu_maxpool;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cfg_relu_en;
    logic       cfg_pool_en;
    logic [6:0] cfg_width;
    int         checks   = 0;
    int         failures = 0;

    ppu_relu_maxpool_if bus ();

    ppu_relu_maxpool #(.MAX_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_relu_en (cfg_relu_en),
        .cfg_pool_en (cfg_pool_en),
        .cfg_width   (cfg_width),
        .s           (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic relu, input logic pool, input logic [6:0] width);
        start       = 1'b1;
        cfg_relu_en = relu;
        cfg_pool_en = pool;
        cfg_width   = width;
        #1;
        chk("start_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        start = 1'b0;
    endtask

    // Presents one pixel and returns just after the edge that accepted it.
    task automatic send(input logic [7:0] d);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    endtask

    task automatic expect_none(input string tag);
        chk({tag, "_novalid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        cfg_relu_en   = 1'b0;
        cfg_pool_en   = 1'b0;
        cfg_width     = 7'd2;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Bypass, ReLU off
        do_start(1'b0, 1'b0, 7'd4);
        send(8'd0);   expect_out("byp0", 8'd0);
        send(8'd127); expect_out("byp127", 8'd127);
        send(8'd128); expect_out("byp128", 8'd128);
        send(8'd255); expect_out("byp255", 8'd255);
        step();
        expect_none("byp_drain");

        // Bypass, ReLU on
        do_start(1'b1, 1'b0, 7'd4);
        send(8'd100); expect_out("relu100", 8'd128);
        send(8'd128); expect_out("relu128", 8'd128);
        send(8'd200); expect_out("relu200", 8'd200);
        step();

        // Pool width 4, ReLU off
        do_start(1'b0, 1'b1, 7'd4);
        send(8'd10); expect_none("p4_r0a");
        send(8'd20); expect_none("p4_r0b");
        send(8'd30); expect_none("p4_r0c");
        send(8'd5);  expect_none("p4_r0d");
        send(8'd15); expect_none("p4_r1a");
        send(8'd12); expect_out("p4_first", 8'd20);
        send(8'd1);  expect_none("p4_r1c");
        send(8'd40); expect_out("p4_second", 8'd40);
        step();
        expect_none("p4_drain");

        // Pool + ReLU width 2
        do_start(1'b1, 1'b1, 7'd2);
        send(8'd100); expect_none("pr_a");
        send(8'd90);  expect_none("pr_b");
        send(8'd50);  expect_none("pr_c");
        send(8'd120); expect_out("pr_out", 8'd128);
        step();

        // Backpressure at the first pooled output
        do_start(1'b0, 1'b1, 7'd4);
        send(8'd10); send(8'd20); send(8'd30); send(8'd5);
        send(8'd15); send(8'd12);
        expect_out("bp_first", 8'd20);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            expect_out("bp_hold", 8'd20);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        send(8'd1);  expect_none("bp_after");
        send(8'd40); expect_out("bp_second", 8'd40);
        step();

        // 4x4 pooled frame
        do_start(1'b0, 1'b1, 7'd4);
        send(8'd1);  send(8'd2);  send(8'd3);  send(8'd4);
        send(8'd5);  send(8'd6);  expect_out("f4_00", 8'd6);
        send(8'd7);  send(8'd8);  expect_out("f4_01", 8'd8);
        send(8'd9);  send(8'd10); send(8'd11); send(8'd12);
        send(8'd13); send(8'd14); expect_out("f4_10", 8'd14);
        send(8'd15); send(8'd16); expect_out("f4_11", 8'd16);
        step();

        // Next frame in bypass, reset mid-row with an output pending
        do_start(1'b0, 1'b0, 7'd4);
        send(8'd77); expect_out("mid_out", 8'd77);
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_out_data", 32'(bus.out_data), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fresh 2x2 frame
        do_start(1'b0, 1'b1, 7'd2);
        send(8'd3); send(8'd9); send(8'd7);
        expect_none("fresh_pre");
        send(8'd5); expect_out("fresh_max", 8'd9);
        step();
        expect_none("fresh_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ppu_relu_maxpool.md
Name: ppu_relu_maxpool

Overview:
- Streaming post-processing stage directly downstream of the post-quantization stage in the PPU.
- Consumes 8-bit quantized activations in offset-128 format, where code 128 represents real zero.
- Applies optional ReLU, then optional 2x2 stride-2 max pooling over a row-major feature-map stream, using an internal half-row line buffer.
- Emits results on a valid/ready stream toward the output buffer writeback.

Parameters:
- MAX_W, 64, maximum feature-map row width in pixels. Must be even and >= 2.
- LB_AW, $clog2(MAX_W/2), line-buffer address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_* and clears all counters and pending output
- cfg_relu_en  in  1  1 = apply ReLU
- cfg_pool_en  in  1  1 = 2x2 max pool; 0 = per-pixel bypass
- cfg_width  in  $clog2(MAX_W)+1  pixels per row; even, 2..MAX_W
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept in_data this cycle
- in_data  in  8  quantized pixel, offset-128
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  8  result pixel, offset-128

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, col=0, row parity=0, pair register cleared, latched cfg cleared (relu=0, pool=0, width=2). Line-buffer contents are don't-care.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready, registered output slot with no combinational valid path. Exception: in_ready=0 during the start cycle.
- start: the latched config takes effect from the next cycle. Clears col, row parity and out_valid, and drops any pending output. Any input presented in the start cycle is not accepted.
- ReLU: p = (relu_en && in_data < 128) ? 128 : in_data. It is applied before pooling, which is equivalent to applying it after.
- Comparisons are unsigned on the 8-bit offset code. A tie keeps either value, since they are equal.
- Bypass mode (pool_en=0):
  - Each accepted pixel p is loaded into out_data with out_valid=1 on the next edge, giving 1-cycle latency.
  - Counters still track col/row but do not affect output.
- Pool mode, per accepted pixel:
  - Even col: store p in the pair register h.
  - Odd col: compute m = max(h, p), k = col>>1.
    - Even row: lb[k] <= m. No output.
    - Odd row: out_data <= max(lb[k], m), out_valid <= 1. Output is 1 cycle after the second pixel of the lower row pair.
- Counter update per accepted pixel:
  - col increments.
  - When col == cfg_width-1: col wraps to 0 and row parity toggles.
- Output rate in pool mode: one output per 4 inputs, i.e. cfg_width/2 outputs per odd row.
- Backpressure: when out_valid && !out_ready, in_ready=0. Output data holds stable until accepted. No input is dropped or duplicated.
- Simultaneous events: an output transfer and a new output load in the same cycle are allowed; the new value replaces the old one, giving full throughput.
- Row-pair boundary: a line-buffer read of lb[k] and a write of the same entry never occur together, because write is on even rows and read is on odd rows.
- Odd or zero cfg_width is illegal and the behaviour is undefined. The bench must not drive it.
- Reset mid-stream clears everything. The next frame requires start.
- Line buffer: MAX_W/2 x 8 flops or inferred RAM. Read is combinational or registered; if registered, the read is issued on the even-col pixel so the result is ready for the odd-col compute, keeping latency unchanged.

Test Plan:
- Bypass, relu off: inputs 0, 127, 128, 255 -> outputs 0, 127, 128, 255, each 1 cycle after acceptance.
- Bypass, relu on: inputs 100, 128, 200 -> outputs 128, 128, 200.
- Pool, width=4, relu off, row0 = 10,20,30,5 and row1 = 15,12,1,40 -> exactly 2 outputs: 20 then 40. No output during row0.
- Pool + relu, width=2, rows 100,90 / 50,120 -> single output 128.
- Backpressure: pool width=4 with out_ready=0 for 5 cycles at the first output -> in_ready=0 and out_data held at 20 until the handshake. Second output is still 40 and no pixel is lost.
- Frame of 4x4 pixels, then start pulse, then reset asserted mid-row of the next frame -> outputs and valid go to 0 immediately. After rst_n release and start, a fresh 2x2 frame yields the correct single max.
